// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - hand-key Morse receiver: debounce, dot/dash classification, letter/space decode
module morse_key_decoder #(
    parameter int UNIT_LOG2 = 21,
    parameter int DEBOUNCE  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key,
    output logic       o_led,
    output logic       o_elem_valid,
    output logic       o_elem_dash,
    output logic       o_char_valid,
    output logic [7:0] o_char
);
    localparam int CW = UNIT_LOG2 + 3;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] U2M1 = CW'((2 << UNIT_LOG2) - 1);
    localparam logic [CW-1:0] U5M1 = CW'((5 << UNIT_LOG2) - 1);
    localparam logic [CW-1:0] U7   = CW'(7 << UNIT_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_WGAP} state_t;

    state_t          r_state, w_state_next;
    logic            r_sync1, r_sync2, r_k;
    logic [DW-1:0]   r_db_cnt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_len;
    logic [4:0]      r_bits;
    logic            r_ovf, r_word_open;
    logic            r_elem_valid, r_elem_dash, r_char_valid;
    logic [7:0]      r_char;
    logic            w_flip, w_rise, w_fall, w_dash;
    logic            w_push, w_emit_letter, w_emit_space;
    logic [7:0]      w_lut;

    assign w_flip = (r_sync2 != r_k) && (r_db_cnt == DW'(DEBOUNCE - 1));
    assign w_rise = w_flip & ~r_k;
    assign w_fall = w_flip & r_k;
    // cnt at the release edge is one less than the press length, hence 2U-1
    assign w_dash = (r_cnt >= U2M1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_k      <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_k      <= ~r_k;
                r_db_cnt <= '0;
            end else if (r_sync2 != r_k) begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        w_emit_letter = 1'b0;
        w_emit_space  = 1'b0;
        case (r_state)
            S_IDLE: if (w_rise) w_state_next = S_MARK;
            S_MARK: if (w_fall) begin
                w_push       = 1'b1;
                w_state_next = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == U2M1) begin
                    w_emit_letter = 1'b1;
                    w_state_next  = w_rise ? S_MARK : S_WGAP;
                end else if (w_rise) begin
                    w_state_next = S_MARK;
                end
            end
            S_WGAP: begin
                if (w_rise) begin
                    w_state_next = S_MARK;
                end else if (r_cnt == U5M1) begin
                    w_emit_space = r_word_open;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Element buffer is keyed {len, bits}; first element ends up most significant
    always_comb begin
        w_lut = 8'h3F;
        if (!r_ovf) begin
            case ({r_len, r_bits})
                {3'd1, 5'd0}:  w_lut = 8'h45; {3'd1, 5'd1}:  w_lut = 8'h54;
                {3'd2, 5'd0}:  w_lut = 8'h49; {3'd2, 5'd1}:  w_lut = 8'h41;
                {3'd2, 5'd2}:  w_lut = 8'h4E; {3'd2, 5'd3}:  w_lut = 8'h4D;
                {3'd3, 5'd0}:  w_lut = 8'h53; {3'd3, 5'd1}:  w_lut = 8'h55;
                {3'd3, 5'd2}:  w_lut = 8'h52; {3'd3, 5'd3}:  w_lut = 8'h57;
                {3'd3, 5'd4}:  w_lut = 8'h44; {3'd3, 5'd5}:  w_lut = 8'h4B;
                {3'd3, 5'd6}:  w_lut = 8'h47; {3'd3, 5'd7}:  w_lut = 8'h4F;
                {3'd4, 5'd0}:  w_lut = 8'h48; {3'd4, 5'd1}:  w_lut = 8'h56;
                {3'd4, 5'd2}:  w_lut = 8'h46; {3'd4, 5'd4}:  w_lut = 8'h4C;
                {3'd4, 5'd6}:  w_lut = 8'h50; {3'd4, 5'd7}:  w_lut = 8'h4A;
                {3'd4, 5'd8}:  w_lut = 8'h42; {3'd4, 5'd9}:  w_lut = 8'h58;
                {3'd4, 5'd10}: w_lut = 8'h43; {3'd4, 5'd11}: w_lut = 8'h59;
                {3'd4, 5'd12}: w_lut = 8'h5A; {3'd4, 5'd13}: w_lut = 8'h51;
                {3'd5, 5'd0}:  w_lut = 8'h35; {3'd5, 5'd1}:  w_lut = 8'h34;
                {3'd5, 5'd3}:  w_lut = 8'h33; {3'd5, 5'd7}:  w_lut = 8'h32;
                {3'd5, 5'd15}: w_lut = 8'h31; {3'd5, 5'd16}: w_lut = 8'h36;
                {3'd5, 5'd24}: w_lut = 8'h37; {3'd5, 5'd28}: w_lut = 8'h38;
                {3'd5, 5'd30}: w_lut = 8'h39; {3'd5, 5'd31}: w_lut = 8'h30;
                default:       w_lut = 8'h3F;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_len        <= 3'd0;
            r_bits       <= 5'd0;
            r_ovf        <= 1'b0;
            r_word_open  <= 1'b0;
            r_elem_valid <= 1'b0;
            r_elem_dash  <= 1'b0;
            r_char_valid <= 1'b0;
            r_char       <= 8'h00;
        end else begin
            if (w_state_next != r_state) r_cnt <= '0;
            else if (r_cnt != U7)        r_cnt <= r_cnt + CW'(1);

            r_elem_valid <= w_push;
            if (w_push) r_elem_dash <= w_dash;

            r_char_valid <= w_emit_letter | w_emit_space;
            if (w_emit_letter)     r_char <= w_lut;
            else if (w_emit_space) r_char <= 8'h20;

            if (w_emit_letter) begin
                r_len  <= 3'd0;
                r_bits <= 5'd0;
                r_ovf  <= 1'b0;
            end else if (w_push) begin
                if (r_len == 3'd5) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_bits <= {r_bits[3:0], w_dash};
                    r_len  <= r_len + 3'd1;
                end
            end

            if (w_emit_letter)                                      r_word_open <= 1'b1;
            else if (r_state == S_WGAP && w_state_next == S_IDLE)   r_word_open <= 1'b0;
        end
    end

    assign o_led        = r_k;
    assign o_elem_valid = r_elem_valid;
    assign o_elem_dash  = r_elem_dash;
    assign o_char_valid = r_char_valid;
    assign o_char       = r_char;
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb/tb_morse_key_decoder.sv - bench for morse_key_decoder with a string-based timing model
module tb_morse_key_decoder;
    localparam int UL = 4;
    localparam int DB = 2;
    localparam int U  = 16;

    logic       clk = 1'b0, rst = 1'b1, key = 1'b0;
    logic       led, ev, ed, cv;
    logic [7:0] ch;

    morse_key_decoder #(.UNIT_LOG2(UL), .DEBOUNCE(DB)) dut (
        .i_clk(clk), .i_rst(rst), .i_key(key), .o_led(led),
        .o_elem_valid(ev), .o_elem_dash(ed), .o_char_valid(cv), .o_char(ch)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    bit m_k, e_ev, e_ed, e_cv, word_open;
    logic [7:0] e_ch;
    bit kh[$], sh[$];
    int t_last, t_fall;
    string elems;
    int n_elem, n_led_hi;
    int chars[$], char_t[$], elem_t[$];

    string pats[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                        "---..", "----."};
    string syms = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    function automatic logic [7:0] decode(string s);
        for (int i = 0; i < 36; i++)
            if (pats[i] == s) return syms.getc(i);
        return 8'h3F;
    endfunction

    // Model: debounced level from raw-key history, then run lengths in unit terms
    always @(posedge clk) begin
        bit prev_k, flip, s;
        int p;
        cyc++;
        if (rst) begin
            kh.delete(); sh.delete();
            m_k = 0; elems = ""; word_open = 0;
            e_ev = 0; e_ed = 0; e_cv = 0; e_ch = 8'h00;
            t_last = cyc; t_fall = cyc;
        end else begin
            prev_k = m_k;
            kh.push_back(key);
            s = (kh.size() >= 3) ? kh[kh.size() - 3] : 1'b0;
            sh.push_back(s);
            if (kh.size() > 4) void'(kh.pop_front());
            if (sh.size() > DB) void'(sh.pop_front());
            flip = (sh.size() == DB);
            foreach (sh[i]) if (sh[i] == m_k) flip = 0;
            if (flip) m_k = !m_k;
            e_ev = 0; e_cv = 0;
            if (flip && !m_k) begin
                p = cyc - t_last;
                e_ev = 1; e_ed = (p >= 2 * U);
                elems = {elems, (p >= 2 * U) ? "-" : "."};
                t_fall = cyc;
            end
            if (!prev_k && elems.len() > 0 && cyc - t_fall == 2 * U) begin
                e_cv = 1; e_ch = decode(elems); elems = ""; word_open = 1;
            end else if (!prev_k && !m_k && word_open && cyc - t_fall == 7 * U) begin
                e_cv = 1; e_ch = 8'h20; word_open = 0;
            end
            if (flip) t_last = cyc;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            vectors++;
            if (led !== m_k || ev !== e_ev || cv !== e_cv || ch !== e_ch ||
                (e_ev && ed !== e_ed) || (ev === 1'b1 && cv === 1'b1)) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got led=%b ev=%b ed=%b cv=%b ch=%h, want led=%b ev=%b ed=%b cv=%b ch=%h",
                         cyc, led, ev, ed, cv, ch, m_k, e_ev, e_ed, e_cv, e_ch);
            end
            if (led === 1'b1) n_led_hi++;
            if (ev === 1'b1) begin n_elem++; elem_t.push_back(cyc); end
            if (cv === 1'b1) begin chars.push_back(int'(ch)); char_t.push_back(cyc); end
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int c_at(int i);
        return (i < chars.size()) ? chars[i] : -1;
    endfunction

    task automatic clear_log();
        chars.delete(); char_t.delete(); elem_t.delete(); n_elem = 0; n_led_hi = 0;
    endtask

    task automatic idle(int n);
        key = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int n);
        key = 1'b1;
        repeat (n) @(negedge clk);
        key = 1'b0;
    endtask

    task automatic send(string pat, int tail);
        for (int i = 0; i < pat.len(); i++) begin
            press((pat.getc(i) == "-") ? 3 * U : U);
            if (i != pat.len() - 1) idle(U);
        end
        idle(tail);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_char", int'(ch), 0);
        chk("reset_led", int'(led), 0);
        chk("reset_char_valid", int'(cv), 0);

        // 1: single short press -> E then space
        clear_log();
        t0 = cyc;
        press(10);
        idle(200);
        chk("t1_elems", n_elem, 1);
        chk("t1_elem_time", (elem_t.size() > 0) ? elem_t[0] - t0 : -1, 14);
        chk("t1_char0", c_at(0), 8'h45);
        chk("t1_char0_time", (char_t.size() > 0) ? char_t[0] - t0 : -1, 46);
        chk("t1_char1", c_at(1), 8'h20);
        chk("t1_char1_time", (char_t.size() > 1) ? char_t[1] - t0 : -1, 126);
        chk("t1_nchars", chars.size(), 2);

        // 2: SOS
        clear_log();
        send("...", 3 * U);
        send("---", 3 * U);
        send("...", 200);
        chk("t2_elems", n_elem, 9);
        chk("t2_char0", c_at(0), 8'h53);
        chk("t2_char1", c_at(1), 8'h4F);
        chk("t2_char2", c_at(2), 8'h53);
        chk("t2_char3", c_at(3), 8'h20);

        // 3: single-cycle glitches are rejected
        clear_log();
        repeat (20) begin
            key = 1'b1;
            @(negedge clk);
            key = 1'b0;
            repeat (4) @(negedge clk);
        end
        idle(20);
        chk("t3_led_high", n_led_hi, 0);
        chk("t3_elems", n_elem, 0);
        chk("t3_chars", chars.size(), 0);

        // 4: overflowing letter, then the longest real pattern
        clear_log();
        send("......", 200);
        send("-----", 200);
        chk("t4_char0", c_at(0), 8'h3F);
        chk("t4_char1", c_at(1), 8'h20);
        chk("t4_char2", c_at(2), 8'h30);
        chk("t4_elems", n_elem, 11);

        // 5: reset during the third dot of S, key still held across reset
        clear_log();
        press(U); idle(U); press(U); idle(U);
        key = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        key = 1'b0;
        idle(60);
        send(".", 200);
        chk("t5_char0", c_at(0), 8'h45);
        chk("t5_char1", c_at(1), 8'h45);
        chk("t5_char2", c_at(2), 8'h20);
        chk("t5_nchars", chars.size(), 3);

        // 6: reset with a word open, then a long quiet key
        clear_log();
        press(U);
        idle(40);
        chk("t6_letter_before_reset", c_at(0), 8'h45);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_char_cleared", int'(ch), 0);
        clear_log();
        idle(500);
        chk("t6_chars", chars.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
